// File: rtl/digit_refresh_ctrl.sv
// Per-frame BCD digit fetcher: reads nine RTC bytes into a shadow bank,
// then commits all 18 digits to the text overlay in a single cycle.
// Ports: clk_i, reset_i (sync, active-high), frame_tick_i,
//   rd_req_o/rd_addr_o/rd_ack_i/rd_data_i (register read port),
//   digits_o (committed digits), upd_o, busy_o, timeout_o, overrun_o.
// Optional: DIGIT_REFRESH_BCD_CHECK_EN adds nibble validation and bcd_err_o.
module digit_refresh_ctrl #(
  parameter int N_BYTES     = 9,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_tick_i,
  output logic                   rd_req_o,
  output logic [3:0]             rd_addr_o,
  input  logic                   rd_ack_i,
  input  logic [7:0]             rd_data_i,
  output logic [8*N_BYTES-1:0]   digits_o,
  output logic                   upd_o,
  output logic                   busy_o,
  output logic                   timeout_o,
  output logic                   overrun_o
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
  ,
  output logic                   bcd_err_o
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
  localparam logic [3:0] LAST = 4'(N_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_NEXT, S_COMMIT
  } state_t;

  state_t              r_state;
  logic [3:0]          r_addr;
  logic [TW-1:0]       r_to_cnt;
  logic [TW-1:0]       w_to_inc;
  logic [7:0]          r_shadow [N_BYTES];
  logic [8*N_BYTES-1:0] w_shadow_flat;
  logic [8*N_BYTES-1:0] r_digits;
  logic [7:0]          w_cap;
  logic                r_req;
  logic                r_busy;
  logic                r_upd;
  logic                r_timeout;

  // Saturating increment so the counter can never wrap back to zero.
  always_comb begin
    w_to_inc = r_to_cnt;
    if (r_to_cnt != '1) w_to_inc = r_to_cnt + 1'b1;
  end

  always_comb begin
    w_shadow_flat = '0;
    for (int i = 0; i < N_BYTES; i++)
      w_shadow_flat[8*i +: 8] = r_shadow[i];
  end

`ifdef DIGIT_REFRESH_BCD_CHECK_EN
  logic [7:0] w_old;
  logic       w_bad_hi;
  logic       w_bad_lo;
  logic       r_bcd_flag;
  logic       r_bcd_err;

  // Invalid nibbles fall back to whatever is currently displayed.
  always_comb begin
    w_old = '0;
    for (int i = 0; i < N_BYTES; i++)
      if (r_addr == 4'(i)) w_old = r_digits[8*i +: 8];
    w_bad_hi = rd_data_i[7:4] > 4'd9;
    w_bad_lo = rd_data_i[3:0] > 4'd9;
    w_cap = {w_bad_hi ? w_old[7:4] : rd_data_i[7:4],
             w_bad_lo ? w_old[3:0] : rd_data_i[3:0]};
  end

  assign bcd_err_o = r_bcd_err;
`else
  assign w_cap = rd_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_to_cnt  <= '0;
      r_digits  <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_upd     <= 1'b0;
      r_timeout <= 1'b0;
      for (int i = 0; i < N_BYTES; i++) r_shadow[i] <= '0;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
      r_bcd_flag <= 1'b0;
      r_bcd_err  <= 1'b0;
`endif
    end else begin
      r_upd <= 1'b0;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
      r_bcd_err <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (frame_tick_i) begin
            r_state  <= S_REQ;
            r_addr   <= '0;
            r_to_cnt <= '0;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
            r_bcd_flag <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          // An ack on the expiry cycle wins over the abort.
          if (rd_ack_i) begin
            r_shadow[r_addr] <= w_cap;
            r_req   <= 1'b0;
            r_state <= S_NEXT;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
            if (w_bad_hi || w_bad_lo) r_bcd_flag <= 1'b1;
`endif
          end else if (w_to_inc == TO_LIM) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_addr    <= '0;
            r_to_cnt  <= '0;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end
        S_NEXT: begin
          r_to_cnt <= '0;
          if (r_addr == LAST) begin
            r_state  <= S_COMMIT;
            r_digits <= w_shadow_flat;
            r_upd    <= 1'b1;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
            r_bcd_err <= r_bcd_flag;
`endif
          end else begin
            r_addr  <= r_addr + 4'd1;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_addr  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req_o  = r_req;
  assign rd_addr_o = r_addr;
  assign digits_o  = r_digits;
  assign upd_o     = r_upd;
  assign busy_o    = r_busy;
  assign timeout_o = r_timeout;
  // Flagged in the same cycle the rejected tick is presented.
  assign overrun_o = frame_tick_i & r_busy;

endmodule

// File: tb/tb_digit_refresh_ctrl.sv
// Directed testbench for digit_refresh_ctrl.
// Models the register source with per-address ack delays.
module tb_digit_refresh_ctrl;

  logic        clk;
  logic        reset_i;
  logic        frame_tick_i;
  logic        rd_req_o;
  logic [3:0]  rd_addr_o;
  logic        rd_ack_i;
  logic [7:0]  rd_data_i;
  logic [71:0] digits_o;
  logic        upd_o;
  logic        busy_o;
  logic        timeout_o;
  logic        overrun_o;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
  logic        bcd_err_o;
`endif

  digit_refresh_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .frame_tick_i (frame_tick_i),
    .rd_req_o     (rd_req_o),
    .rd_addr_o    (rd_addr_o),
    .rd_ack_i     (rd_ack_i),
    .rd_data_i    (rd_data_i),
    .digits_o     (digits_o),
    .upd_o        (upd_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .overrun_o    (overrun_o)
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
    ,
    .bcd_err_o    (bcd_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] rdata [9];
  int         dly   [9];
  bit         hold  [9];
  int         wcnt;

  logic        req_log  [300];
  logic [3:0]  addr_log [300];
  logic        upd_log  [300];
  logic        busy_log [300];
  logic        to_log   [300];
  logic        ovr_log  [300];
  logic        err_log  [300];
  int upd_cnt, upd_k, ovr_cnt, ovr_k;

  // Register source: acks after dly[addr] waiting cycles unless held off.
  initial begin
    rd_ack_i = 1'b0;
    rd_data_i = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (rd_req_o && !hold[rd_addr_o] && wcnt >= dly[rd_addr_o]) begin
        rd_ack_i = 1'b1;
        rd_data_i = rdata[rd_addr_o];
        wcnt = 0;
      end else if (rd_req_o) begin
        rd_ack_i = 1'b0;
        rd_data_i = '0;
        wcnt++;
      end else begin
        rd_ack_i = 1'b0;
        rd_data_i = '0;
        wcnt = 0;
      end
    end
  end

  task automatic setup(input logic [7:0] base);
    for (int i = 0; i < 9; i++) begin
      rdata[i] = base + 8'(i);
      dly[i] = 0;
      hold[i] = 1'b0;
    end
  endtask

  // Tick at k=0 (cycle T); log outputs for cycles T..T+n.
  task automatic frame(input int n, input int tick2_k, input int rst_k);
    upd_cnt = 0; upd_k = -1; ovr_cnt = 0; ovr_k = -1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      frame_tick_i = (k == 0) || (k == tick2_k);
      reset_i = (k == rst_k);
      #1;
      req_log[k]  = rd_req_o;
      addr_log[k] = rd_addr_o;
      upd_log[k]  = upd_o;
      busy_log[k] = busy_o;
      to_log[k]   = timeout_o;
      ovr_log[k]  = overrun_o;
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
      err_log[k]  = bcd_err_o;
`else
      err_log[k]  = 1'b0;
`endif
      if (upd_o) begin
        upd_cnt++;
        if (upd_k < 0) upd_k = k;
      end
      if (overrun_o) begin
        ovr_cnt++;
        if (ovr_k < 0) ovr_k = k;
      end
    end
    @(negedge clk);
    frame_tick_i = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    frame_tick_i = 1'b0;
    setup(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_req_o, rd_addr_o, upd_o, busy_o, timeout_o, overrun_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0",
               {rd_req_o, rd_addr_o, upd_o, busy_o, timeout_o, overrun_o});
    end
    checks++;
    if (digits_o !== 72'd0) begin
      failures++;
      $display("FAIL reset_digits got=%h exp=0", digits_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    setup(8'h10);
    frame(22, -1, -1);
    checks++;
    if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_start got=%b%b exp=01", busy_log[0], busy_log[1]);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (req_log[1+2*i] !== 1'b1 || addr_log[1+2*i] !== 4'(i)) begin
        failures++;
        $display("FAIL basic_req%0d got=%b/%0d exp=1/%0d",
                 i, req_log[1+2*i], addr_log[1+2*i], i);
      end
      checks++;
      if (req_log[2+2*i] !== 1'b0) begin
        failures++;
        $display("FAIL basic_gap%0d got=%b exp=0", i, req_log[2+2*i]);
      end
    end
    checks++;
    if (upd_k !== 19 || upd_cnt !== 1) begin
      failures++;
      $display("FAIL basic_upd got=k%0d/n%0d exp=k19/n1", upd_k, upd_cnt);
    end
    checks++;
    if (busy_log[19] !== 1'b1 || busy_log[20] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_end got=%b%b exp=10", busy_log[19], busy_log[20]);
    end
    checks++;
    if (digits_o !== 72'h181716151413121110) begin
      failures++;
      $display("FAIL basic_digits got=%h exp=181716151413121110", digits_o);
    end
  endtask

  task automatic test_delay();
    setup(8'h20);
    dly[4] = 3;
    frame(25, -1, -1);
    for (int k = 9; k <= 12; k++) begin
      checks++;
      if (req_log[k] !== 1'b1 || addr_log[k] !== 4'd4) begin
        failures++;
        $display("FAIL delay_hold_k%0d got=%b/%0d exp=1/4", k, req_log[k], addr_log[k]);
      end
    end
    checks++;
    if (req_log[13] !== 1'b0) begin
      failures++;
      $display("FAIL delay_gap got=%b exp=0", req_log[13]);
    end
    checks++;
    if (upd_k !== 22 || upd_cnt !== 1) begin
      failures++;
      $display("FAIL delay_upd got=k%0d/n%0d exp=k22/n1", upd_k, upd_cnt);
    end
    checks++;
    if (digits_o !== 72'h282726252423222120) begin
      failures++;
      $display("FAIL delay_digits got=%h exp=282726252423222120", digits_o);
    end
  endtask

  task automatic test_timeout();
    setup(8'h30);
    hold[2] = 1'b1;
    frame(265, -1, -1);
    checks++;
    if (req_log[259] !== 1'b1 || addr_log[259] !== 4'd2 || to_log[259] !== 1'b0) begin
      failures++;
      $display("FAIL to_wait got=%b/%0d/%b exp=1/2/0",
               req_log[259], addr_log[259], to_log[259]);
    end
    checks++;
    if (req_log[260] !== 1'b0 || busy_log[260] !== 1'b0 || to_log[260] !== 1'b1) begin
      failures++;
      $display("FAIL to_abort got=%b/%b/%b exp=0/0/1",
               req_log[260], busy_log[260], to_log[260]);
    end
    checks++;
    if (upd_cnt !== 0) begin
      failures++;
      $display("FAIL to_no_upd got=%0d exp=0", upd_cnt);
    end
    checks++;
    if (digits_o !== 72'h282726252423222120) begin
      failures++;
      $display("FAIL to_digits got=%h exp=282726252423222120", digits_o);
    end
    setup(8'h40);
    frame(22, -1, -1);
    checks++;
    if (upd_k !== 19 || digits_o !== 72'h484746454443424140) begin
      failures++;
      $display("FAIL to_recover got=k%0d/%h exp=k19/484746454443424140", upd_k, digits_o);
    end
    checks++;
    if (timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=1", timeout_o);
    end
  endtask

  task automatic test_overrun();
    setup(8'h50);
    frame(22, 5, -1);
    checks++;
    if (ovr_cnt !== 1 || ovr_k !== 5) begin
      failures++;
      $display("FAIL ovr_mid got=k%0d/n%0d exp=k5/n1", ovr_k, ovr_cnt);
    end
    checks++;
    if (upd_cnt !== 1 || upd_k !== 19 || digits_o !== 72'h585756555453525150) begin
      failures++;
      $display("FAIL ovr_mid_commit got=k%0d/n%0d/%h exp=k19/n1/585756555453525150",
               upd_k, upd_cnt, digits_o);
    end
    setup(8'h60);
    frame(24, 19, -1);
    checks++;
    if (ovr_cnt !== 1 || ovr_k !== 19) begin
      failures++;
      $display("FAIL ovr_commit got=k%0d/n%0d exp=k19/n1", ovr_k, ovr_cnt);
    end
    checks++;
    if (busy_log[20] !== 1'b0 || req_log[21] !== 1'b0 || upd_cnt !== 1) begin
      failures++;
      $display("FAIL ovr_commit_ignored got=%b/%b/%0d exp=0/0/1",
               busy_log[20], req_log[21], upd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    setup(8'h70);
    frame(30, -1, 8);
    checks++;
    if (req_log[7] !== 1'b1 || busy_log[8] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b/%b exp=1/1", req_log[7], busy_log[8]);
    end
    checks++;
    if ({req_log[9], addr_log[9], upd_log[9], busy_log[9], to_log[9]} !== 8'd0) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=0",
               {req_log[9], addr_log[9], upd_log[9], busy_log[9], to_log[9]});
    end
    checks++;
    if (upd_cnt !== 0 || digits_o !== 72'd0) begin
      failures++;
      $display("FAIL rst_digits got=n%0d/%h exp=n0/0", upd_cnt, digits_o);
    end
  endtask

`ifdef DIGIT_REFRESH_BCD_CHECK_EN
  task automatic test_bcd();
    setup(8'h11);
    for (int i = 0; i < 9; i++) rdata[i] = 8'h11;
    frame(22, -1, -1);
    checks++;
    if (digits_o !== {9{8'h11}} || err_log[19] !== 1'b0) begin
      failures++;
      $display("FAIL bcd_prep got=%h/%b exp=all11/0", digits_o, err_log[19]);
    end
    rdata[0] = 8'h3C;
    frame(22, -1, -1);
    checks++;
    if (digits_o !== {{8{8'h11}}, 8'h31}) begin
      failures++;
      $display("FAIL bcd_replace got=%h exp=111111111111111131", digits_o);
    end
    checks++;
    if (err_log[19] !== 1'b1 || upd_log[19] !== 1'b1 || err_log[20] !== 1'b0) begin
      failures++;
      $display("FAIL bcd_err got=%b/%b/%b exp=1/1/0", err_log[19], upd_log[19], err_log[20]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_timeout();
    test_overrun();
    test_reset_mid();
`ifdef DIGIT_REFRESH_BCD_CHECK_EN
    test_bcd();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_refresh_ctrl.md
Name: digit_refresh_ctrl

Overview:
- Once per video frame, fetches the nine BCD time, date and chrono bytes from the clock-register source over a req/ack read port.
- Reads into a shadow bank, then commits all 18 digits to the on-screen text generator in one cycle, so no frame ever shows a half-updated time.
- Sits between the RTC bus interface and the VGA text overlay, which consumes the committed digits.

Parameters:
- N_BYTES, 9, number of registers fetched per frame; address map: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 chrono sec, 7 chrono min, 8 chrono hour.
- TIMEOUT_CYC, 255, maximum cycles to wait for rd_ack_i per byte before the frame is aborted.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- frame_tick_i  in  1  single-cycle pulse at the start of vertical blanking.
- rd_req_o  out  1  read request to the register source.
- rd_addr_o  out  4  register address, valid while rd_req_o=1.
- rd_ack_i  in  1  read acknowledge; rd_data_i is valid in the same cycle.
- rd_data_i  in  8  read data, {tens[7:4], units[3:0]}.
- digits_o  out  72  committed digits; byte i at [8i+7:8i], tens in the high nibble.
- upd_o  out  1  one-cycle pulse on the cycle digits_o changes.
- busy_o  out  1  high from frame-tick acceptance until commit or abort.
- timeout_o  out  1  sticky flag, set on a timeout abort, cleared only by reset.
- overrun_o  out  1  one-cycle pulse when frame_tick_i arrives while busy_o=1.

Behaviour:
- Reset values:
  - digits_o=0, shadow bank=0, addr counter=0.
  - rd_req_o=0, rd_addr_o=0, upd_o=0, busy_o=0, timeout_o=0, overrun_o=0.
  - state=IDLE, timeout counter=0.
- A reset mid-fetch abandons the fetch immediately; nothing is committed.
- IDLE: on frame_tick_i, go to REQ on the next cycle with addr=0; busy_o=1 from that cycle.
- REQ:
  - rd_req_o=1, rd_addr_o=addr, both held stable until ack.
  - When rd_ack_i=1: capture rd_data_i into shadow[addr] and go to NEXT.
  - Otherwise increment the timeout counter; when it reaches TIMEOUT_CYC with no ack, go to IDLE, set timeout_o, leave digits_o unchanged, clear busy_o.
- NEXT:
  - rd_req_o=0 for exactly one cycle; timeout counter cleared.
  - If addr==N_BYTES-1, go to COMMIT; else addr+1 and go to REQ.
- COMMIT: digits_o <= shadow (all 72 bits in the same edge), upd_o=1 for 1 cycle, go to IDLE; busy_o=0 on the following cycle.
- Latency with an ack in the first REQ cycle of each byte:
  - tick at cycle T; first request at T+1; each byte takes 2 cycles; COMMIT at T+19; digits_o/upd_o visible at T+19.
- rd_ack_i outside REQ is ignored.
- rd_ack_i coincident with a timeout expiry counts as an ack; no abort.
- frame_tick_i while busy_o=1: ignored, overrun_o pulses, the current fetch continues.
- frame_tick_i in the COMMIT cycle counts as busy: overrun_o pulses.
- Address wraps only by returning to 0 in IDLE; rd_addr_o never exceeds N_BYTES-1.
- The timeout counter is wide enough for TIMEOUT_CYC and saturates.

Optional Feature:
- Macro: DIGIT_REFRESH_BCD_CHECK_EN.
- When defined:
  - Each captured nibble > 9 is replaced by the corresponding nibble currently held in digits_o.
  - A port bcd_err_o (out, 1) pulses high in the COMMIT cycle if any replacement occurred during that frame.
  - Its per-frame tracking flag clears on entry to REQ with addr=0.
- When undefined: raw data is committed unchanged; bcd_err_o does not exist.

Test Plan:
- Reset, then tick; the source acks immediately with data 8'h10+i for address i -> rd_addr_o sequences 0..8; upd_o at T+19; digits_o=72'h18_17_16_15_14_13_12_11_10; busy_o low at T+20.
- Ack delayed 3 cycles on address 4 -> rd_req_o and rd_addr_o=4 held stable for 4 cycles; commit at T+22; values correct.
- Ack withheld on address 2 with TIMEOUT_CYC=255 -> abort after 255 waiting cycles; timeout_o=1; digits_o keeps its prior value; no upd_o; the next tick fetches normally and timeout_o stays 1.
- Second frame_tick_i at T+5 -> overrun_o pulses once at T+5; a single commit at T+19.
- reset_i asserted at T+8 -> all outputs are reset values the next cycle; no upd_o; rd_req_o=0.
- With DIGIT_REFRESH_BCD_CHECK_EN, previous digits_o all 8'h11 and address 0 returning 8'h3C -> byte 0 commits 8'h31; bcd_err_o pulses with upd_o.
